// File: rtl/stream_scheduler.sv
// Round-robin scheduler sharing one filter between NR_STREAMS sample streams.
// Define STREAM_SCHED_TIMEOUT_EN to abandon a fetch after TIMEOUT cycles.
module stream_scheduler #(
    parameter int DWIDTH         = 16,
    parameter int NR_STREAMS     = 16,
    parameter int NR_STREAMS_LOG = 4,
    parameter int TIMEOUT        = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NR_STREAMS-1:0]        stream_en,
    output logic [NR_STREAMS-1:0]        req_in,
    input  logic [NR_STREAMS-1:0]        ack_in,
    input  logic [0:NR_STREAMS*DWIDTH-1] data_in,
    input  logic                         flt_req_in,
    output logic                         flt_ack_in,
    output logic [0:DWIDTH-1]            flt_data_in,
    input  logic                         flt_req_out,
    output logic                         flt_ack_out,
    input  logic [0:DWIDTH-1]            flt_data_out,
    output logic [NR_STREAMS-1:0]        req_out,
    input  logic [NR_STREAMS-1:0]        ack_out,
    output logic [0:DWIDTH-1]            data_out,
    output logic [NR_STREAMS_LOG-1:0]    cur_stream,
    output logic                         busy,
    output logic                         timeout
);

    typedef enum logic [2:0] {
        IDLE, FETCH, FEED, DRAIN, DELIVER, NEXT
    } state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

`ifdef STREAM_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    state_t                      state_q, state_d;
    logic [NR_STREAMS_LOG-1:0]   cur_q, cur_d;
    logic [NR_STREAMS-1:0]       req_in_q, req_in_d;
    logic [NR_STREAMS-1:0]       req_out_q, req_out_d;
    logic                        flt_ack_in_q, flt_ack_in_d;
    logic                        flt_ack_out_q, flt_ack_out_d;
    logic [0:DWIDTH-1]           flt_data_in_q, flt_data_in_d;
    logic [0:DWIDTH-1]           data_out_q, data_out_d;
    logic                        busy_q, busy_d;
    logic                        timeout_q, timeout_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    int                          cur_i;

    // First enabled index at or after start, wrapping past the top.
    function automatic logic [NR_STREAMS_LOG-1:0] pick(
        input logic [NR_STREAMS-1:0] en,
        input int                    start
    );
        logic [NR_STREAMS_LOG-1:0] r;
        logic [NR_STREAMS-1:0]     sh;
        logic                      found;
        int                        j;
        r     = '0;
        found = 1'b0;
        for (int k = 0; k < NR_STREAMS; k++) begin
            j  = (start + k) % NR_STREAMS;
            sh = en >> j;
            if (!found && sh[0]) begin
                r     = NR_STREAMS_LOG'(j);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [NR_STREAMS-1:0] onehot(
        input logic [NR_STREAMS_LOG-1:0] idx
    );
        logic [NR_STREAMS-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return one << idx;
    endfunction

    function automatic logic bit_at(
        input logic [NR_STREAMS-1:0]     v,
        input logic [NR_STREAMS_LOG-1:0] idx
    );
        logic [NR_STREAMS-1:0] sh;
        sh = v >> idx;
        return sh[0];
    endfunction

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        req_in_d      = req_in_q;
        req_out_d     = req_out_q;
        flt_ack_in_d  = flt_ack_in_q;
        flt_ack_out_d = flt_ack_out_q;
        flt_data_in_d = flt_data_in_q;
        data_out_d    = data_out_q;
        timeout_d     = 1'b0;
        cnt_d         = cnt_q;
        cur_i         = int'(cur_q);

        case (state_q)
            IDLE: begin
                if (|stream_en) begin
                    cur_d    = pick(stream_en, cur_i);
                    req_in_d = onehot(cur_d);
                    cnt_d    = '0;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                if (bit_at(ack_in, cur_q)) begin
                    flt_data_in_d = data_in[cur_i*DWIDTH +: DWIDTH];
                    req_in_d      = '0;
                    flt_ack_in_d  = 1'b1;
                    state_d       = FEED;
                end else if (TO_EN && cnt_q == CW'(TIMEOUT - 1)) begin
                    req_in_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = NEXT;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FEED: begin
                if (flt_req_in && flt_ack_in_q) begin
                    flt_ack_in_d  = 1'b0;
                    flt_ack_out_d = 1'b1;
                    state_d       = DRAIN;
                end
            end
            DRAIN: begin
                if (flt_req_out && flt_ack_out_q) begin
                    data_out_d    = flt_data_out;
                    flt_ack_out_d = 1'b0;
                    req_out_d     = onehot(cur_q);
                    state_d       = DELIVER;
                end
            end
            DELIVER: begin
                if (bit_at(ack_out, cur_q)) begin
                    req_out_d = '0;
                    state_d   = NEXT;
                end
            end
            NEXT: begin
                if (|stream_en) begin
                    cur_d    = pick(stream_en, cur_i + 1);
                    req_in_d = onehot(cur_d);
                    cnt_d    = '0;
                    state_d  = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cur_q         <= '0;
            req_in_q      <= '0;
            req_out_q     <= '0;
            flt_ack_in_q  <= 1'b0;
            flt_ack_out_q <= 1'b0;
            flt_data_in_q <= '0;
            data_out_q    <= '0;
            busy_q        <= 1'b0;
            timeout_q     <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            req_in_q      <= req_in_d;
            req_out_q     <= req_out_d;
            flt_ack_in_q  <= flt_ack_in_d;
            flt_ack_out_q <= flt_ack_out_d;
            flt_data_in_q <= flt_data_in_d;
            data_out_q    <= data_out_d;
            busy_q        <= busy_d;
            timeout_q     <= timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign req_in      = req_in_q;
    assign req_out     = req_out_q;
    assign flt_ack_in  = flt_ack_in_q;
    assign flt_ack_out = flt_ack_out_q;
    assign flt_data_in = flt_data_in_q;
    assign data_out    = data_out_q;
    assign cur_stream  = cur_q;
    assign busy        = busy_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_stream_scheduler.sv
// Directed bench for stream_scheduler: vector table plus stall/reset/timeout sequences.
module tb_stream_scheduler;

    localparam int DW = 16;
    localparam int NS = 16;
    localparam int NL = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     stream_en;
    logic [NS-1:0]     req_in;
    logic [NS-1:0]     ack_in;
    logic [0:NS*DW-1]  data_in;
    logic              flt_req_in;
    logic              flt_ack_in;
    logic [0:DW-1]     flt_data_in;
    logic              flt_req_out;
    logic              flt_ack_out;
    logic [0:DW-1]     flt_data_out;
    logic [NS-1:0]     req_out;
    logic [NS-1:0]     ack_out;
    logic [0:DW-1]     data_out;
    logic [NL-1:0]     cur_stream;
    logic              busy;
    logic              timeout;

    logic [NS-1:0]     src_rdy;
    logic [NS-1:0]     snk_rdy;
    logic              flt_out_rdy;
    logic [0:DW-1]     hold;
    logic              has;
    int                cycle = 0;
    int                checks = 0;
    int                errors = 0;

    stream_scheduler #(
        .DWIDTH(DW), .NR_STREAMS(NS), .NR_STREAMS_LOG(NL), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .stream_en(stream_en),
        .req_in(req_in), .ack_in(ack_in), .data_in(data_in),
        .flt_req_in(flt_req_in), .flt_ack_in(flt_ack_in),
        .flt_data_in(flt_data_in), .flt_req_out(flt_req_out),
        .flt_ack_out(flt_ack_out), .flt_data_out(flt_data_out),
        .req_out(req_out), .ack_out(ack_out), .data_out(data_out),
        .cur_stream(cur_stream), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    assign ack_in  = req_in & src_rdy;
    assign ack_out = req_out & snk_rdy;

    // Pass-through filter holding at most one sample.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            has  <= 1'b0;
            hold <= '0;
        end else if (flt_req_in && flt_ack_in) begin
            has  <= 1'b1;
            hold <= flt_data_in;
        end else if (flt_req_out && flt_ack_out) begin
            has <= 1'b0;
        end
    end

    assign flt_req_in   = !has;
    assign flt_req_out  = has && flt_out_rdy;
    assign flt_data_out = hold;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_deliver(output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (req_out != '0) begin
                ok  = 1'b1;
                cyc = cycle;
                return;
            end
        end
    endtask

    task automatic restart(input logic [NS-1:0] en);
        rst       = 1'b1;
        stream_en = en;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [15:0]         en;
        logic [0:2][3:0]     s;
        logic [0:2][15:0]    d;
    } vec_t;

    vec_t tab[7];

    initial begin
        int  c;
        int  prev;
        bit  ok;
        bit  bad;
        bit  got;
        int  nf;
        logic [15:0] exp_r;

        tab[0] = '{16'h0005, {4'd0, 4'd2, 4'd0},
                   {16'h1111, 16'h2222, 16'h1111}};
        tab[1] = '{16'h8000, {4'd15, 4'd15, 4'd15},
                   {16'hFFFF, 16'hFFFF, 16'hFFFF}};
        tab[2] = '{16'h0009, {4'd0, 4'd3, 4'd0},
                   {16'h1111, 16'h3333, 16'h1111}};
        tab[3] = '{16'hFFFF, {4'd0, 4'd1, 4'd2},
                   {16'h1111, 16'h1111, 16'h2222}};
        tab[4] = '{16'h8001, {4'd0, 4'd15, 4'd0},
                   {16'h1111, 16'hFFFF, 16'h1111}};
        tab[5] = '{16'h0120, {4'd5, 4'd8, 4'd5},
                   {16'h5555, 16'h8888, 16'h5555}};
        tab[6] = '{16'h000E, {4'd1, 4'd2, 4'd3},
                   {16'h1111, 16'h2222, 16'h3333}};

        for (int i = 0; i < NS; i++)
            data_in[i*DW +: DW] = (i == 0) ? 16'h1111 : 16'(32'h1111 * i);
        src_rdy     = '1;
        snk_rdy     = '1;
        flt_out_rdy = 1'b1;
        stream_en   = '0;
        rst         = 1'b1;

        // Reset state and idle with nothing enabled
        @(negedge clk);
        check("rst req_in", 32'(req_in), 0);
        check("rst req_out", 32'(req_out), 0);
        check("rst flt_acks", 32'({flt_ack_in, flt_ack_out}), 0);
        check("rst busy_to", 32'({busy, timeout}), 0);
        check("rst cur", 32'(cur_stream), 0);
        check("rst data", 32'({flt_data_in, data_out}), 0);
        rst = 1'b0;
        bad = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (busy || req_in != '0 || req_out != '0 ||
                flt_ack_in || flt_ack_out)
                bad = 1'b1;
        end
        check("idle quiet", 32'(bad), 0);

        // Table of round-robin service orders
        for (int v = 0; v < 7; v++) begin
            restart(tab[v].en);
            prev = 0;
            for (int k = 0; k < 3; k++) begin
                wait_deliver(c, ok);
                check($sformatf("v%0d.%0d deliver", v, k), 32'(ok), 1);
                if (ok) begin
                    exp_r = 16'h1 << tab[v].s[k];
                    check($sformatf("v%0d.%0d req_out", v, k),
                          32'(req_out), 32'(exp_r));
                    check($sformatf("v%0d.%0d data", v, k),
                          32'(data_out), 32'(tab[v].d[k]));
                    check($sformatf("v%0d.%0d cur", v, k),
                          32'(cur_stream), 32'(tab[v].s[k]));
                    if (k > 0)
                        check($sformatf("v%0d.%0d turn", v, k),
                              32'(c - prev), 5);
                    prev = c;
                end
            end
        end

        // Sink stall on stream 3
        snk_rdy = ~16'h0008;
        restart(16'h0008);
        wait_deliver(c, ok);
        check("stall deliver", 32'(ok), 1);
        check("stall req_out", 32'(req_out), 32'h0008);
        check("stall data", 32'(data_out), 32'h3333);
        bad = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_out != 16'h0008 || data_out != 16'h3333 ||
                req_in != '0 || !busy)
                bad = 1'b1;
        end
        check("stall stable", 32'(bad), 0);
        snk_rdy = '1;
        @(negedge clk);
        check("stall release req_out", 32'(req_out), 0);
        check("stall release req_in", 32'(req_in), 0);
        @(negedge clk);
        check("stall reselect", 32'(req_in), 32'h0008);
        check("stall cur", 32'(cur_stream), 3);

        // Reset while draining the filter
        flt_out_rdy = 1'b0;
        restart(16'h0006);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (flt_ack_out) got = 1'b1;
        end
        check("drain reached", 32'(got), 1);
        check("drain cur", 32'(cur_stream), 1);
        check("drain flt_data_in", 32'(flt_data_in), 32'h1111);
        rst = 1'b1;
        #1;
        check("async req", 32'({req_in, req_out}), 0);
        check("async acks", 32'({flt_ack_in, flt_ack_out}), 0);
        check("async busy", 32'({busy, timeout}), 0);
        check("async data", 32'({flt_data_in, data_out}), 0);
        check("async cur", 32'(cur_stream), 0);
        flt_out_rdy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("restart req_in", 32'(req_in), 32'h0002);
        check("restart busy", 32'(busy), 1);

        // Source 1 never acknowledges
        src_rdy = ~16'h0002;
        restart(16'h0006);
`ifdef STREAM_SCHED_TIMEOUT_EN
        got = 1'b0;
        bad = 1'b0;
        nf  = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (flt_ack_in) bad = 1'b1;
            if (timeout) got = 1'b1;
            else if (req_in == 16'h0002) nf++;
        end
        check("to pulse", 32'(got), 1);
        check("to fetch cycles", 32'(nf), 8);
        check("to no filter", 32'(bad), 0);
        check("to req cleared", 32'(req_in), 0);
        @(negedge clk);
        check("to one cycle", 32'(timeout), 0);
        check("to next stream", 32'(req_in), 32'h0004);
        wait_deliver(c, ok);
        check("to deliver", 32'(ok), 1);
        check("to req_out", 32'(req_out), 32'h0004);
        check("to data", 32'(data_out), 32'h2222);
`else
        bad = 1'b0;
        nf  = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (timeout || flt_ack_in) bad = 1'b1;
            if (req_in == 16'h0002) nf++;
        end
        check("wait no timeout", 32'(bad), 0);
        check("wait fetch held", 32'(nf), 30);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
